// File: rtl/vga_sync.sv
// vga_sync: 640x480 @ 60 Hz VGA timing generator running from the 100 MHz
// system clock. Produces the pixel enable, registered active-low sync pulses,
// the active-video flag, pixel coordinates and a once-per-frame tick.
module vga_sync #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // All coordinate constants are taken at 10 bits to match x and y.
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       X_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]       HS_START  = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]       HS_END    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]       VS_START  = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]       VS_END    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0]       H_VIS     = 10'(H_DISPLAY);
    localparam logic [9:0]       V_VIS     = 10'(V_DISPLAY);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             tick;
    logic             x_wrap;

    // Pixel enable is decoded straight from the divider register.
    assign tick   = (div_q == DIV_LAST);
    assign x_wrap = tick && (x_q == X_LAST);

    // Next-state logic: divider, raster counters and the syncs derived from
    // the next counter values so the syncs move on the same edge as x/y.
    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        x_d   = x_q;
        y_d   = y_q;
        if (tick) begin
            x_d = x_wrap ? 10'd0 : x_q + 10'd1;
        end
        if (x_wrap) begin
            y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
        end
        hsync_d = !((x_d >= HS_START) && (x_d <= HS_END));
        vsync_d = !((y_d >= VS_START) && (y_d <= VS_END));
    end

    // State registers; reset acts immediately, even mid-line or mid-frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign p_tick     = tick;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign x          = x_q;
    assign y          = y_q;
    // Active video is purely combinational from the registered coordinates,
    // so it reads 1 at (0,0) while reset is held.
    assign video_on   = (x_q < H_VIS) && (y_q < V_VIS);
    // Last pixel of the frame, qualified by the pixel enable.
    assign frame_tick = x_wrap && (y_q == Y_LAST);

endmodule
